// File: rtl/conv_win_pkg.sv
// Shared defaults and index helper for the sliding convolution window buffer.
package conv_win_pkg;

    localparam int CW_W_DEF      = 12;
    localparam int CW_K_DEF      = 3;
    localparam int CW_FILL_W_DEF = $clog2(CW_K_DEF + 1);

    // Flat element index of window element (r,c) for a k-wide window
    function automatic int win_idx(input int r, input int c, input int k);
        return (r * k) + c;
    endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Column-in / window-out handshake bundle for conv_window_buffer.
// CONV_WIN_PARALLEL_LOAD_EN adds the load_en/load_data parallel-load signals.
interface conv_window_buffer_if
    import conv_win_pkg::*;
#(
    parameter int W = CW_W_DEF,
    parameter int K = CW_K_DEF
);

    logic                       col_valid;
    logic                       col_ready;
    logic [K*W-1:0]             col_data;
    logic                       line_start;
    logic                       out_valid;
    logic                       out_ready;
    logic [K*K*W-1:0]           win_data;
    logic [$clog2(K+1)-1:0]     fill_cnt;
`ifdef CONV_WIN_PARALLEL_LOAD_EN
    logic                       load_en;
    logic [K*K*W-1:0]           load_data;
`endif

    modport master (
        output col_valid, col_data, line_start, out_ready,
        input  col_ready, out_valid, win_data, fill_cnt
`ifdef CONV_WIN_PARALLEL_LOAD_EN
        , output load_en, load_data
`endif
    );

    modport slave (
        input  col_valid, col_data, line_start, out_ready,
        output col_ready, out_valid, win_data, fill_cnt
`ifdef CONV_WIN_PARALLEL_LOAD_EN
        , input load_en, load_data
`endif
    );

endinterface

// File: rtl/conv_win_row.sv
// One K-deep, W-bit window row: shifts toward column 0 and accepts new data at column K-1.
module conv_win_row
    import conv_win_pkg::*;
#(
    parameter int W = CW_W_DEF,
    parameter int K = CW_K_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift_en,
    input  logic           load_en,
    input  logic [K*W-1:0] load_data,
    input  logic [W-1:0]   shift_in,
    output logic [K*W-1:0] row_data
);

    logic [W-1:0] col_r [K];

    // Row storage: parallel load wins over shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < K; c++) begin
                col_r[c] <= {W{1'b0}};
            end
        end else if (load_en) begin
            for (int c = 0; c < K; c++) begin
                col_r[c] <= load_data[c*W +: W];
            end
        end else if (shift_en) begin
            for (int c = 0; c < K - 1; c++) begin
                col_r[c] <= col_r[c+1];
            end
            col_r[K-1] <= shift_in;
        end else begin
            for (int c = 0; c < K; c++) begin
                col_r[c] <= col_r[c];
            end
        end
    end

    // Flatten row storage, column 0 in the low bits
    always_comb begin
        row_data = {(K*W){1'b0}};
        for (int c = 0; c < K; c++) begin
            row_data[c*W +: W] = col_r[c];
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// K x K sliding window buffer fed one column per accepted handshake.
// CONV_WIN_PARALLEL_LOAD_EN enables the whole-window parallel load path.
module conv_window_buffer
    import conv_win_pkg::*;
#(
    parameter int W = CW_W_DEF,
    parameter int K = CW_K_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    conv_window_buffer_if.slave bus
);

    localparam int            FW        = $clog2(K + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(K);
    localparam logic [FW-1:0] FILL_ONE  = {{(FW-1){1'b0}}, 1'b1};

    logic               take_s;
    logic               load_s;
    logic               accept_s;
    logic               col_ready_s;
    logic               out_valid_r;
    logic               out_valid_nxt_s;
    logic [FW-1:0]      fill_r;
    logic [FW-1:0]      fill_nxt_s;
    logic [K*K*W-1:0]   win_r;
    logic [K*K*W-1:0]   win_nxt_s;
    logic [K*K*W-1:0]   shift_win_s;
    logic [K*K*W-1:0]   load_win_s;
    logic               win_upd_s;
    logic [K*W-1:0]     row_q_s  [K];
    logic [K*W-1:0]     row_ld_s [K];

    // A new window may be taken whenever the output slot is free or being drained
    assign take_s = !out_valid_r || bus.out_ready;

`ifdef CONV_WIN_PARALLEL_LOAD_EN
    assign load_s      = bus.load_en && take_s;
    assign col_ready_s = take_s && !bus.load_en;
    assign load_win_s  = bus.load_data;
`else
    assign load_s      = 1'b0;
    assign col_ready_s = take_s;
    assign load_win_s  = {(K*K*W){1'b0}};
`endif

    assign accept_s      = bus.col_valid && col_ready_s;
    assign bus.col_ready = col_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.fill_cnt  = fill_r;
    assign bus.win_data  = win_r;

    for (genvar r = 0; r < K; r++) begin : g_row
`ifdef CONV_WIN_PARALLEL_LOAD_EN
        assign row_ld_s[r] = bus.load_data[r*K*W +: K*W];
`else
        assign row_ld_s[r] = {(K*W){1'b0}};
`endif
        conv_win_row #(.W(W), .K(K)) u_row (
            .clk       (clk),
            .rst_n     (rst_n),
            .shift_en  (accept_s),
            .load_en   (load_s),
            .load_data (row_ld_s[r]),
            .shift_in  (bus.col_data[r*W +: W]),
            .row_data  (row_q_s[r])
        );
    end

    // Window as it will look after the current column shifts in
    always_comb begin
        shift_win_s = {(K*K*W){1'b0}};
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    shift_win_s[win_idx(r, c, K)*W +: W] = row_q_s[r][(c+1)*W +: W];
                end else begin
                    shift_win_s[win_idx(r, c, K)*W +: W] = bus.col_data[r*W +: W];
                end
            end
        end
    end

    // Fill counter, output valid and window register next state
    always_comb begin
        fill_nxt_s      = fill_r;
        out_valid_nxt_s = out_valid_r;
        win_upd_s       = 1'b0;
        win_nxt_s       = shift_win_s;
        if (load_s) begin
            fill_nxt_s      = FILL_FULL;
            out_valid_nxt_s = 1'b1;
            win_upd_s       = 1'b1;
            win_nxt_s       = load_win_s;
        end else if (accept_s) begin
            if (bus.line_start) begin
                fill_nxt_s = FILL_ONE;
            end else if (fill_r == FILL_FULL) begin
                fill_nxt_s = FILL_FULL;
            end else begin
                fill_nxt_s = fill_r + FILL_ONE;
            end
            out_valid_nxt_s = (fill_nxt_s == FILL_FULL);
            win_upd_s       = out_valid_nxt_s;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Handshake state and registered window output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            fill_r      <= {FW{1'b0}};
            win_r       <= {(K*K*W){1'b0}};
        end else begin
            out_valid_r <= out_valid_nxt_s;
            fill_r      <= fill_nxt_s;
            if (win_upd_s) begin
                win_r <= win_nxt_s;
            end else begin
                win_r <= win_r;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed and random checks of conv_window_buffer against a column-queue reference model.
module tb_conv_window_buffer;

    localparam int W  = 12;
    localparam int K  = 3;
    localparam int KW = K * W;
    localparam int WW = K * K * W;
    localparam int FW = $clog2(K + 1);

    logic clk;
    logic rst_n;
    int   total;
    int   fails;

    // Reference model: the fresh columns of the current line (newest last)
    logic [KW-1:0] m_q [$];
    logic          m_valid;
    logic [WW-1:0] m_win;

    conv_window_buffer_if #(.W(W), .K(K)) bus ();

    conv_window_buffer #(.W(W), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] mkcol(input int a, input int b, input int c);
        return {W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [WW-1:0] model_window();
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(r*K+c)*W +: W] = m_q[c][r*W +: W];
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_win   = '0;
    endtask

    task automatic model_clock(input logic cv, input logic [KW-1:0] cd, input logic ls, input logic ordy);
        bit ready;
        ready = !m_valid || ordy;
        if (cv && ready) begin
            if (ls) m_q.delete();
            m_q.push_back(cd);
            if (m_q.size() > K) void'(m_q.pop_front());
            m_valid = (m_q.size() == K);
            if (m_valid) m_win = model_window();
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk_outputs();
        chk("out_valid", WW'(bus.out_valid), WW'(m_valid));
        chk("fill_cnt", WW'(bus.fill_cnt), WW'(m_q.size()));
        if (m_valid) chk("win_data", bus.win_data, m_win);
    endtask

    // One clock: drive, check ready before the edge, advance model, check outputs after
    task automatic do_step(input logic cv, input logic [KW-1:0] cd, input logic ls, input logic ordy);
        bus.col_valid  = cv;
        bus.col_data   = cd;
        bus.line_start = ls;
        bus.out_ready  = ordy;
        #1;
        chk("col_ready", WW'(bus.col_ready), WW'(!m_valid || ordy));
        @(posedge clk);
        model_clock(cv, cd, ls, ordy);
        #1;
        chk_outputs();
    endtask

`ifdef CONV_WIN_PARALLEL_LOAD_EN
    task automatic do_load(input logic [WW-1:0] ld, input logic ordy);
        bus.load_en   = 1'b1;
        bus.load_data = ld;
        bus.col_valid = 1'b1;
        bus.col_data  = mkcol(90, 91, 92);
        bus.out_ready = ordy;
        #1;
        chk("load_col_ready", WW'(bus.col_ready), WW'(0));
        @(posedge clk);
        if (!m_valid || ordy) begin
            m_q.delete();
            for (int c = 0; c < K; c++) begin
                logic [KW-1:0] col;
                for (int r = 0; r < K; r++) col[r*W +: W] = ld[(r*K+c)*W +: W];
                m_q.push_back(col);
            end
            m_valid = 1'b1;
            m_win   = ld;
        end
        #1;
        chk_outputs();
        bus.load_en = 1'b0;
    endtask
`endif

    initial begin
        logic [WW-1:0] hold;
        logic [KW-1:0] rcol;
        int            win_cnt;
        total = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.col_valid  = 1'b0;
        bus.col_data   = '0;
        bus.line_start = 1'b0;
        bus.out_ready  = 1'b0;
`ifdef CONV_WIN_PARALLEL_LOAD_EN
        bus.load_en   = 1'b0;
        bus.load_data = '0;
`endif
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", WW'(bus.out_valid), WW'(0));
        chk("rst_fill", WW'(bus.fill_cnt), WW'(0));
        chk("rst_win", bus.win_data, WW'(0));
        rst_n = 1'b1;

        // First window from three back-to-back columns
        for (int i = 0; i < 3; i++) begin
            do_step(1'b1, mkcol(3*i+1, 3*i+2, 3*i+3), 1'b0, 1'b1);
            chk("fill_seq", WW'(bus.fill_cnt), WW'(i + 1));
            chk("first_valid", WW'(bus.out_valid), WW'(i == 2));
        end
        chk("w00", WW'(bus.win_data[0 +: W]), WW'(1));
        chk("w02", WW'(bus.win_data[2*W +: W]), WW'(7));
        chk("w22", WW'(bus.win_data[8*W +: W]), WW'(9));

        // Back-pressure holds everything, release accepts in the same cycle
        hold = bus.win_data;
        repeat (5) begin
            do_step(1'b1, mkcol(10, 11, 12), 1'b0, 1'b0);
            chk("stall_win", bus.win_data, hold);
            chk("stall_fill", WW'(bus.fill_cnt), WW'(3));
        end
        do_step(1'b1, mkcol(10, 11, 12), 1'b0, 1'b1);
        chk("release_w02", WW'(bus.win_data[2*W +: W]), WW'(10));
        chk("release_w00", WW'(bus.win_data[0 +: W]), WW'(4));

        // Line start restarts the fill
        do_step(1'b1, mkcol(10, 11, 12), 1'b1, 1'b1);
        chk("ls_fill", WW'(bus.fill_cnt), WW'(1));
        chk("ls_valid", WW'(bus.out_valid), WW'(0));
        do_step(1'b0, mkcol(77, 77, 77), 1'b1, 1'b1);
        chk("ls_ignored", WW'(bus.fill_cnt), WW'(1));
        do_step(1'b1, mkcol(13, 14, 15), 1'b0, 1'b1);
        chk("ls_valid2", WW'(bus.out_valid), WW'(0));
        do_step(1'b1, mkcol(16, 17, 18), 1'b0, 1'b1);
        chk("ls_valid3", WW'(bus.out_valid), WW'(1));
        chk("ls_w00", WW'(bus.win_data[0 +: W]), WW'(10));

        // Reset mid-line discards the partial fill
        do_step(1'b1, mkcol(30, 31, 32), 1'b1, 1'b1);
        do_step(1'b1, mkcol(33, 34, 35), 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", WW'(bus.out_valid), WW'(0));
        chk("mid_rst_fill", WW'(bus.fill_cnt), WW'(0));
        chk("mid_rst_win", bus.win_data, WW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_step(1'b1, mkcol(40+i, 50+i, 60+i), 1'b0, 1'b1);
            chk("post_rst_valid", WW'(bus.out_valid), WW'(i == 2));
        end

        // Continuous stream of ten columns yields eight consecutive windows
        win_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            do_step(1'b1, mkcol(100+i, 200+i, 300+i), (i == 0), 1'b1);
            if (bus.out_valid) begin
                win_cnt++;
                chk("stream_w00", WW'(bus.win_data[0 +: W]), WW'(100 + i - 2));
            end
        end
        chk("stream_windows", WW'(win_cnt), WW'(8));
        do_step(1'b0, mkcol(0, 0, 0), 1'b0, 1'b1);

`ifdef CONV_WIN_PARALLEL_LOAD_EN
        hold = '0;
        for (int i = 0; i < K*K; i++) hold[i*W +: W] = W'(i + 1);
        do_load(hold, 1'b1);
        chk("load_fill", WW'(bus.fill_cnt), WW'(3));
        chk("load_win", bus.win_data, hold);
        do_step(1'b1, mkcol(5, 6, 7), 1'b0, 1'b1);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rcol = KW'({$urandom(), $urandom()});
            do_step(($urandom_range(0, 3) != 0), rcol, ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 SHALL have parameter W, default 12, pixel word width in bits.
REQ-002 SHALL have parameter K, default 3, window edge; window holds K*K words; legal K 2..7.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 col_valid  input  1  new column present on col_data.
REQ-006 col_ready  output  1  block accepts column this cycle.
REQ-007 col_data  input  K*W  column, row r at bits [r*W +: W], r=0 top.
REQ-008 line_start  input  1  qualifies accepted column as first column of a new image line.
REQ-009 out_valid  output  1  win_data holds a complete window.
REQ-010 out_ready  input  1  consumer accepts window.
REQ-011 win_data  output  K*K*W  window, element (r,c) at bits [(r*K+c)*W +: W], c=0 oldest column.
REQ-012 fill_cnt  output  $clog2(K+1)  valid columns currently held, saturating at K.

Function
REQ-013 Column accepted SHALL mean col_valid && col_ready at a rising edge.
REQ-014 col_ready SHALL equal (!out_valid || out_ready), combinational, and is 0 while load_en is high when PARALLEL_LOAD is compiled in.
REQ-015 On acceptance, storage columns SHALL shift c <- c+1 and col_data SHALL enter column K-1.
REQ-016 On acceptance without line_start, fill_cnt SHALL increment, saturating at K.
REQ-017 On acceptance with line_start, fill_cnt SHALL become 1; older columns are stale and excluded.
REQ-018 line_start without col_valid SHALL be ignored.
REQ-019 If the acceptance leaves fill_cnt == K, out_valid SHALL be 1 and win_data the new window on the next cycle (latency 1).
REQ-020 If the acceptance leaves fill_cnt < K, out_valid SHALL be 0 on the next cycle.
REQ-021 With out_valid && !out_ready, win_data, out_valid and fill_cnt SHALL hold unchanged.
REQ-022 With out_valid && out_ready and no acceptance, out_valid SHALL fall next cycle.
REQ-023 With out_valid && out_ready and simultaneous acceptance, the new window SHALL replace the old with no bubble.
REQ-024 Steady state with col_valid and out_ready held high SHALL deliver one window per cycle.

Reset
REQ-025 While rst_n is low: storage, win_data = 0, out_valid = 0, fill_cnt = 0.
REQ-026 Reset asserted mid-line SHALL discard partial fill; first window after release needs K fresh columns.
REQ-027 col_ready SHALL be 1 during the first cycle after reset release.

Configuration
REQ-028 Macro CONV_WIN_PARALLEL_LOAD_EN SHALL gate the parallel-load feature.
REQ-029 Defined: ports load_en (1) and load_data (K*K*W, same layout as win_data) SHALL exist.
REQ-030 Defined: load_en accepted when (!out_valid || out_ready); it SHALL load all K*K words, set fill_cnt = K, out_valid = 1 next cycle; it has priority over col_valid.
REQ-031 Undefined: load_en and load_data SHALL be absent; behaviour per REQ-013..027 only.

Structure
REQ-032 Package conv_win_pkg SHALL hold default W and K, the fill_cnt width localparam, and the (r,c) flat-index function.
REQ-033 Sub-module conv_win_row SHALL implement one K-deep W-bit shift row with shift enable and parallel load; top instantiates K rows.
REQ-034 Handshake, fill counter and output register SHALL reside in the top module.

Verification (K=3, W=12)
REQ-035 Feed columns {1,2,3},{4,5,6},{7,8,9} back to back, out_ready=1 -> out_valid rises one cycle after third accept; (0,0)=1, (0,2)=7, (2,2)=9; fill_cnt 1,2,3.
REQ-036 Window valid, out_ready=0 for 5 cycles with col_valid=1 -> col_ready=0, win_data and fill_cnt stable; on out_ready=1 next column accepted same cycle.
REQ-037 Fill 3 columns, then accept column {A,B,C} with line_start=1 -> fill_cnt=1, out_valid=0 until two more accepts.
REQ-038 Assert rst_n=0 after 2 columns -> all outputs 0; after release 3 new columns needed for out_valid.
REQ-039 Continuous stream of 10 columns, out_ready=1 -> 8 windows on 8 consecutive cycles, each shifted by one column.
REQ-040 With CONV_WIN_PARALLEL_LOAD_EN: load_en with load_data 1..9 while col_valid=1 -> load wins, col_ready=0, out_valid=1 next cycle, win_data = 1..9, fill_cnt=3.
